// File: rtl/key_pkg.sv
// Shared types and constants for the key dispatch block: FSM states,
// classification limits, default FIFO depth and the byte classifier.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DISP,
        CTRL
    } key_state_e;

    localparam logic [7:0] KEY_CTRL_LIMIT    = 8'h20;
    localparam logic [7:0] KEY_DEL           = 8'h7F;
    localparam int         KEY_DEPTH_DEFAULT = 8;

    // Control bytes: C0 range plus DEL; everything else is printable.
    function automatic logic key_is_ctrl(input logic [7:0] b);
        return (b < KEY_CTRL_LIMIT) || (b == KEY_DEL);
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous FIFO holding received key bytes.
// Ports: clk_i, rst_i (sync, active high), push_i/data_i write side,
//   pop_i/data_o read side (data_o shows the head combinationally),
//   full_o, empty_o, count_o (exact occupancy 0..DEPTH).
// A push while full is accepted only when a pop happens in the same cycle.
module key_fifo
    import key_pkg::*;
#(
    parameter int DEPTH = KEY_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [7:0]    data_i,
    input  logic          pop_i,
    output logic [7:0]    data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ONE_PTR = {{(AW-1){1'b0}}, 1'b1};

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    // When full, the slot being written is the one being popped.
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + ONE_PTR;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + ONE_PTR;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + ONE_CNT;
        end else if (do_pop && !do_push) begin
            count_d = count_q - ONE_CNT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/key_dispatch.sv
// Byte scheduler from the SPI receive driver to the display and control
// consumers: edge-detects NewKey, queues bytes, and hands them out one at
// a time in arrival order over valid/ready.
// Ports: sys_clk, rst (sync, active high), key_data/key_new from the SPI
//   driver, disp_*/ctrl_* handshakes, fifo_count, overflow/ovf_clr,
//   ovf_count.
// Macro KEY_DISPATCH_OVF_COUNT_EN builds the saturating drop counter;
//   otherwise ovf_count is tied to zero.
module key_dispatch
    import key_pkg::*;
#(
    parameter int DEPTH = KEY_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic [7:0]    key_data,
    input  logic          key_new,
    output logic [7:0]    disp_data,
    output logic          disp_valid,
    input  logic          disp_ready,
    output logic [7:0]    ctrl_data,
    output logic          ctrl_valid,
    input  logic          ctrl_ready,
    output logic [AW:0]   fifo_count,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic [7:0]    ovf_count
);

    key_state_e  state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        kn_q;
    logic        ovf_q, ovf_d;
    logic        push;
    logic        pop;
    logic        drop;
    logic [7:0]  head;
    logic        full;
    logic        empty;

    // One push per NewKey high period.
    assign push = key_new & ~kn_q;
    assign drop = push & full & ~pop;

    key_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i   (sys_clk),
        .rst_i   (rst),
        .push_i  (push),
        .data_i  (key_data),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        pop        = 1'b0;
        disp_valid = 1'b0;
        ctrl_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop    = 1'b1;
                    hold_d = head;
                    state_d = key_is_ctrl(head) ? CTRL : DISP;
                end
            end
            DISP: begin
                disp_valid = 1'b1;
                if (disp_ready) begin
                    state_d = IDLE;
                end
            end
            CTRL: begin
                ctrl_valid = 1'b1;
                if (ctrl_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign disp_data = hold_q;
    assign ctrl_data = hold_q;

    // Set wins over clear.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    assign overflow = ovf_q;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= 8'h00;
            // High so a NewKey already asserted at release is ignored.
            kn_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            kn_q    <= key_new;
            ovf_q   <= ovf_d;
        end
    end

`ifdef KEY_DISPATCH_OVF_COUNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (drop) begin
            if (ovf_cnt_q != 8'hFF) begin
                ovf_cnt_d = ovf_cnt_q + 8'd1;
            end
        end else if (ovf_clr) begin
            ovf_cnt_d = 8'h00;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            ovf_cnt_q <= 8'h00;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_count = ovf_cnt_q;
`else
    assign ovf_count = 8'h00;
`endif

endmodule

// File: tb/tb_key_dispatch.sv
// Self-checking bench for key_dispatch: queue-based reference model,
// per-cycle compare, directed scenarios and randomized traffic.
module tb_key_dispatch;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          sys_clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    key_data = 8'h00;
    logic          key_new = 1'b0;
    logic [7:0]    disp_data;
    logic          disp_valid;
    logic          disp_ready = 1'b0;
    logic [7:0]    ctrl_data;
    logic          ctrl_valid;
    logic          ctrl_ready = 1'b0;
    logic [AW:0]   fifo_count;
    logic          overflow;
    logic          ovf_clr = 1'b0;
    logic [7:0]    ovf_count;

    key_dispatch #(.DEPTH(DEPTH)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .key_data   (key_data),
        .key_new    (key_new),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .ctrl_data  (ctrl_data),
        .ctrl_valid (ctrl_valid),
        .ctrl_ready (ctrl_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .ovf_count  (ovf_count)
    );

    always #5 sys_clk = ~sys_clk;

`ifdef KEY_DISPATCH_OVF_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus one in-flight byte.
    logic [7:0] mq[$];
    logic [7:0] m_hold;
    bit         m_busy;
    bit         m_isctrl;
    bit         m_kn;
    bit         m_ovf;
    int         m_cnt;
    bit         m_started = 1'b0;

    function automatic bit is_ctrl(input logic [7:0] b);
        return (b < 8'h20) || (b == 8'h7F);
    endfunction

    always @(posedge sys_clk) begin
        bit pop_now;
        bit psh;
        bit drop;
        m_started = 1'b1;
        if (rst) begin
            mq.delete();
            m_hold = 8'h00;
            m_busy = 1'b0;
            m_isctrl = 1'b0;
            m_kn = 1'b1;
            m_ovf = 1'b0;
            m_cnt = 0;
        end else begin
            pop_now = !m_busy && (mq.size() > 0);
            psh = key_new && !m_kn;
            drop = psh && (mq.size() == DEPTH) && !pop_now;
            if (m_busy && (m_isctrl ? ctrl_ready : disp_ready))
                m_busy = 1'b0;
            if (pop_now) begin
                m_hold = mq.pop_front();
                m_busy = 1'b1;
                m_isctrl = is_ctrl(m_hold);
            end
            if (psh && !drop)
                mq.push_back(key_data);
            if (drop) begin
                m_ovf = 1'b1;
                if (CNT_EN && m_cnt < 255) m_cnt++;
            end else if (ovf_clr) begin
                m_ovf = 1'b0;
                m_cnt = 0;
            end
            m_kn = key_new;
        end
    end

    int n_dhs = 0;
    int n_chs = 0;
    int n_cv  = 0;

    always @(negedge sys_clk) begin
        if (m_started) begin
            chk("disp_valid", 32'(disp_valid), 32'(m_busy && !m_isctrl));
            chk("ctrl_valid", 32'(ctrl_valid), 32'(m_busy && m_isctrl));
            chk("disp_data", 32'(disp_data), 32'(m_hold));
            chk("ctrl_data", 32'(ctrl_data), 32'(m_hold));
            chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
            if (disp_valid && disp_ready) n_dhs++;
            if (ctrl_valid && ctrl_ready) n_chs++;
            if (ctrl_valid) n_cv++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [7:0] b);
        key_data = b;
        key_new = 1'b1;
        tick();
        key_new = 1'b0;
        tick();
    endtask

    int d0, c0, v0;

    initial begin
        tick(3);
        @(negedge sys_clk);
        chk("rst_disp_valid", 32'(disp_valid), 32'h0);
        chk("rst_ctrl_valid", 32'(ctrl_valid), 32'h0);
        chk("rst_fifo_count", 32'(fifo_count), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_data", 32'(disp_data), 32'h0);
        chk("rst_ovf_count", 32'(ovf_count), 32'h0);
        rst = 1'b0;
        tick(2);

        // Single printable byte.
        disp_ready = 1'b1;
        ctrl_ready = 1'b1;
        d0 = n_dhs; c0 = n_chs; v0 = n_cv;
        key_data = 8'h41;
        key_new = 1'b1;
        tick();
        @(negedge sys_clk);
        chk("single_cnt1", 32'(fifo_count), 32'd1);
        chk("single_nv1", 32'(disp_valid), 32'h0);
        tick();
        @(negedge sys_clk);
        chk("single_valid", 32'(disp_valid), 32'h1);
        chk("single_data", 32'(disp_data), 32'h41);
        tick();
        @(negedge sys_clk);
        chk("single_drop", 32'(disp_valid), 32'h0);
        tick(2);
        key_new = 1'b0;
        tick(3);
        chk("single_hs", 32'(n_dhs - d0), 32'd1);
        chk("single_nochs", 32'(n_chs - c0), 32'd0);
        chk("single_nocv", 32'(n_cv - v0), 32'd0);

        // Mixed order with control path stalled.
        ctrl_ready = 1'b0;
        d0 = n_dhs; c0 = n_chs;
        pulse(8'h61);
        pulse(8'h0D);
        pulse(8'h62);
        tick(20);
        @(negedge sys_clk);
        chk("mix_cvalid", 32'(ctrl_valid), 32'h1);
        chk("mix_cdata", 32'(ctrl_data), 32'h0D);
        chk("mix_blocked", 32'(fifo_count), 32'd1);
        chk("mix_dhs1", 32'(n_dhs - d0), 32'd1);
        ctrl_ready = 1'b1;
        tick(6);
        chk("mix_dhs2", 32'(n_dhs - d0), 32'd2);
        chk("mix_chs", 32'(n_chs - c0), 32'd1);

        // Overflow: 10 bytes, both consumers stalled.
        disp_ready = 1'b0;
        ctrl_ready = 1'b0;
        for (int i = 0; i < 10; i++) pulse(8'h41 + 8'(i));
        @(negedge sys_clk);
        chk("ovf_full", 32'(fifo_count), 32'd8);
        chk("ovf_held", 32'(disp_valid), 32'h1);
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_cnt", 32'(ovf_count), CNT_EN ? 32'd1 : 32'd0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge sys_clk);
        chk("clr_flag", 32'(overflow), 32'h0);
        chk("clr_cnt", 32'(ovf_count), 32'h0);

        // Full FIFO: push lands on the pop cycle after a handshake.
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0;
        key_data = 8'h55;
        key_new = 1'b1;
        tick();
        @(negedge sys_clk);
        chk("sim_cnt", 32'(fifo_count), 32'd8);
        chk("sim_ovf", 32'(overflow), 32'h0);
        chk("sim_data", 32'(disp_data), 32'h42);
        key_new = 1'b0;
        tick();

        // Reset with NewKey held high while a byte is offered.
        key_data = 8'h5A;
        key_new = 1'b1;
        rst = 1'b1;
        tick(2);
        @(negedge sys_clk);
        chk("rr_dvalid", 32'(disp_valid), 32'h0);
        chk("rr_cnt", 32'(fifo_count), 32'h0);
        chk("rr_data", 32'(disp_data), 32'h0);
        rst = 1'b0;
        tick(3);
        @(negedge sys_clk);
        chk("rr_nopush", 32'(fifo_count), 32'h0);
        chk("rr_nvalid", 32'(disp_valid), 32'h0);
        key_new = 1'b0;
        tick();
        key_data = 8'h30;
        key_new = 1'b1;
        tick();
        @(negedge sys_clk);
        chk("rr_push", 32'(fifo_count), 32'd1);
        tick();
        @(negedge sys_clk);
        chk("rr_valid", 32'(disp_valid), 32'h1);
        chk("rr_vdata", 32'(disp_data), 32'h30);
        key_new = 1'b0;
        disp_ready = 1'b1;
        tick(2);

        // Randomized traffic.
        for (int blk = 0; blk < 15; blk++) begin
            int rp;
            rp = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 90);
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 2) == 0) key_new = ~key_new;
                if ($urandom_range(0, 2) == 0)
                    key_data = 8'($urandom_range(0, 31));
                else if ($urandom_range(0, 9) == 0)
                    key_data = 8'h7F;
                else
                    key_data = 8'($urandom);
                disp_ready = ($urandom_range(0, 99) < rp);
                ctrl_ready = ($urandom_range(0, 99) < rp);
                ovf_clr = ($urandom_range(0, 25) == 0);
                rst = ($urandom_range(0, 600) == 0);
                tick();
            end
        end
        rst = 1'b0;
        ovf_clr = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
